// File: rtl/latch_wr_pkg.sv
// Shared definitions for the latch bank write controller.
//   wr_state_e    : controller phase (IDLE/SETUP/PULSE/HOLD)
//   cnt_width()   : phase counter width large enough for the longest phase
package latch_wr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } wr_state_e;

   // Width holding the largest phase length; one spare bit keeps the
   // width non-zero when every phase lasts a single cycle.
   function automatic int cnt_width(input int setup_cyc, input int pulse_cyc,
                                    input int hold_cyc);
      int mx;
      mx = setup_cyc;
      if (pulse_cyc > mx) mx = pulse_cyc;
      if (hold_cyc > mx) mx = hold_cyc;
      return $clog2(mx) + 1;
   endfunction

endpackage

// File: rtl/latch_bank_writer_phase_timer.sv
// Loadable down-counter timing one controller phase.
//   clk_in      : clock, rising edge
//   rst_in      : synchronous active-high reset (count -> 0)
//   load_in     : load load_val_in this edge (wins over counting)
//   load_val_in : cycles remaining minus one for the new phase
//   zero_out    : count has reached zero (last cycle of the phase)
module phase_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             load_in,
   input  logic [CNT_W-1:0] load_val_in,
   output logic             zero_out
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_in) begin
         cnt_d = load_val_in;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_out = (cnt_q == '0);

endmodule

// File: rtl/latch_bank_writer.sv
// Write controller for an external bank of level-sensitive D latches.
// Accepts one write per handshake, then sequences SETUP -> PULSE -> HOLD
// so the data bus is stable around the one-hot enable pulse.
//   clk_in / rst_in : clock, synchronous active-high reset
//   wr_valid_in, wr_ready_out, wr_addr_in, wr_data_in : write request port
//   lat_d_out       : data bus to every latch
//   lat_en_out      : one-hot latch enables, straight from flops
//   busy_out        : write sequence in progress
//   done_out        : one-cycle pulse on the first IDLE cycle after a write
//
// Handshake: a request transfers on a rising edge where wr_valid_in and
// wr_ready_out are both high; addr/data are sampled only on that edge and
// the producer keeps the request stable until it transfers.
module latch_bank_writer
   import latch_wr_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 2,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 wr_valid_in,
   output logic                 wr_ready_out,
   input  logic [ADDR_W-1:0]    wr_addr_in,
   input  logic [DATA_W-1:0]    wr_data_in,
   output logic [DATA_W-1:0]    lat_d_out,
   output logic [2**ADDR_W-1:0] lat_en_out,
   output logic                 busy_out,
   output logic                 done_out
);

   localparam int N     = 2**ADDR_W;
   localparam int CNT_W = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

   // Timer counts down to zero, so each phase loads its length minus one.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

   wr_state_e          state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [N-1:0]       en_q, en_d;
   logic               done_q, done_d;
   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_load_val;
   logic               tmr_zero;
   logic [N-1:0]       addr_onehot;

   assign addr_onehot = {{(N-1){1'b0}}, 1'b1} << addr_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      en_d         = '0;
      done_d       = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      case (state_q)
         ST_IDLE: begin
            // Ready is high throughout IDLE, so valid alone completes it.
            if (wr_valid_in) begin
               addr_d       = wr_addr_in;
               data_d       = wr_data_in;
               state_d      = ST_SETUP;
               tmr_load     = 1'b1;
               tmr_load_val = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               state_d      = ST_PULSE;
               tmr_load     = 1'b1;
               tmr_load_val = PULSE_LD;
               en_d         = addr_onehot;
            end
         end
         ST_PULSE: begin
            // Enable is registered in lockstep with the state, so it rises
            // and falls exactly on the PULSE entry/exit edges.
            if (tmr_zero) begin
               state_d      = ST_HOLD;
               tmr_load     = 1'b1;
               tmr_load_val = HOLD_LD;
            end else begin
               en_d = addr_onehot;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         en_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         en_q    <= en_d;
         done_q  <= done_d;
      end
   end

   phase_timer #(
      .CNT_W(CNT_W)
   ) u_phase_timer (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .load_in    (tmr_load),
      .load_val_in(tmr_load_val),
      .zero_out   (tmr_zero)
   );

   assign wr_ready_out = (state_q == ST_IDLE);
   assign busy_out     = (state_q != ST_IDLE);
   assign done_out     = done_q;
   assign lat_d_out    = data_q;
   assign lat_en_out   = en_q;

endmodule

// File: doc/latch_bank_writer.md
# latch_bank_writer

Synchronous write controller for a bank of level-sensitive D latches (en/d style, transparent while enable high). It accepts one write per valid/ready handshake, then drives data and a one-hot latch enable through a SETUP -> PULSE -> HOLD sequence. The latch array stays outside this block and samples the data while its enable is high, holding it otherwise. The block sits between a clocked producer and the latch storage, and guarantees data stability around every enable pulse.

## Interface
- DATA_W, 8, width of latch data bus
- ADDR_W, 2, latch select width; bank size N = 2**ADDR_W
- SETUP_CYC, 1, cycles data is stable before enable rises (>=1)
- PULSE_CYC, 2, cycles enable stays high (>=1)
- HOLD_CYC, 1, cycles data is stable after enable falls (>=1)

- clk_in  input  1  single clock, rising edge
- rst_in  input  1  reset, synchronous, active-high
- wr_valid_in  input  1  write request valid
- wr_ready_out  output  1  block can accept a request (state IDLE)
- wr_addr_in  input  ADDR_W  target latch index
- wr_data_in  input  DATA_W  write data
- lat_d_out  output  DATA_W  data bus to all latches (d_in side)
- lat_en_out  output  N  one-hot latch enables (en_in side)
- busy_out  output  1  high in SETUP, PULSE and HOLD
- done_out  output  1  one-cycle pulse when a write completes

## Operation
- States: IDLE, SETUP, PULSE, HOLD, encoded as an enum. One phase counter is reloaded on every state entry.
- IDLE: wr_ready_out=1, lat_en_out=0. On the edge where wr_valid_in&wr_ready_out, register addr and data, drive lat_d_out=data, go to SETUP.
- SETUP: lat_en_out=0. After SETUP_CYC cycles go to PULSE.
- PULSE: lat_en_out=1<<addr. After PULSE_CYC cycles go to HOLD.
- HOLD: lat_en_out=0. After HOLD_CYC cycles go to IDLE and assert done_out for exactly one cycle.
- lat_d_out changes only on an accept edge or on reset. It keeps the last written value indefinitely while in IDLE.
- lat_en_out is driven directly from flops, with no combinational decode after the register, so the enables are glitch-free. At most one bit is ever set.
- wr_valid_in while busy: ignored. The producer must hold the request until ready. Addr and data are sampled only on the accept edge.
- Every ADDR_W value is valid. There is no error path.
- Reset: rst_in high at an edge forces the following values:
  - state IDLE, counter 0
  - lat_en_out=0, lat_d_out=0
  - done_out=0, busy_out=0
  - wr_ready_out=1 from the cycle after that edge
- Reset mid-PULSE: the enable drops at the reset edge and the write is abandoned with no done_out. The target latch contents are undefined.
- Reset has priority over a simultaneous handshake.

## Timing
- The accept edge is E0.
- busy_out is high from E0 until E0+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- lat_en_out rises at E0+SETUP_CYC and falls at E0+SETUP_CYC+PULSE_CYC.
- done_out is high in the cycle after edge E0+S+P+H, which is also the first IDLE cycle.
- wr_ready_out is high during the done_out cycle, so a back-to-back accept is allowed there.
- Maximum throughput is one write per S+P+H+1 cycles. With defaults that is 5 cycles.
- wr_ready_out, busy_out and done_out are decoded only from registered state.

## Structure
- Package latch_wr_pkg holds:
  - the state enum typedef (IDLE/SETUP/PULSE/HOLD)
  - a function returning the counter width, $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC))+1
- Sub-module phase_timer: loadable down-counter with load value input and a zero flag. It is instantiated once and reloaded on each state transition.
- Top level contains the FSM, the address/data capture registers and the one-hot enable register.

## Test plan
- Reset then idle: hold rst_in 3 cycles -> all outputs 0 except wr_ready_out=1. No enable activity for 20 cycles.
- Single write, defaults: addr=2, data=0xA5 at E0.
  - lat_d_out=0xA5 from E0.
  - lat_en_out=4'b0100 for exactly the 2 cycles after E0+1.
  - done_out pulses once at the cycle after E0+4.
  - lat_d_out is still 0xA5 afterwards.
- Back-to-back: valid held continuously with addr 0..3, data 0x11/0x22/0x33/0x44.
  - Accepts are exactly 5 cycles apart.
  - Each enable is one-hot and in order.
  - A behavioral latch model ends with 0x11, 0x22, 0x33, 0x44.
- Busy stall: change wr_data_in to 0xFF during PULSE of a 0x3C write -> lat_d_out remains 0x3C and the model latch captures 0x3C.
- Reset mid-pulse: assert rst_in during PULSE -> lat_en_out=0 and lat_d_out=0 at that edge, with no done_out.
- Parameter sweep: SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2.
  - Enable high exactly 1 cycle, starting at E0+3.
  - done_out at the cycle after E0+6.
